// File: rtl/shift_req_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module : shift_req_arbiter_if
// Brief  : Request/response bundle between N_REQ requesters and the shared
//          shift arbiter.
// Rev    : 1.0 - initial release
// ============================================================================
interface shift_req_arbiter_if #(
  parameter int N_REQ = 2
);
  localparam int ID_W = $clog2(N_REQ);

  logic [N_REQ-1:0]    req_valid;
  logic [N_REQ-1:0]    req_ready;
  logic [N_REQ*32-1:0] req_data;
  logic [N_REQ*5-1:0]  req_shamt;
  logic [N_REQ-1:0]    req_arith;
  logic [N_REQ-1:0]    req_left;
  logic                rsp_valid;
  logic                rsp_ready;
  logic [31:0]         rsp_data;
  logic [ID_W-1:0]     rsp_id;
  logic                busy;

  modport master (
    output req_valid, req_data, req_shamt, req_arith, req_left, rsp_ready,
    input  req_ready, rsp_valid, rsp_data, rsp_id, busy
  );

  modport slave (
    input  req_valid, req_data, req_shamt, req_arith, req_left, rsp_ready,
    output req_ready, rsp_valid, rsp_data, rsp_id, busy
  );
endinterface
`default_nettype wire

// File: rtl/shift_req_arbiter.sv
`default_nettype none
// ============================================================================
// Module : shift_req_arbiter
// Brief  : One 32-bit barrel shifter shared round-robin by N_REQ requesters,
//          IDLE -> EXEC -> RESP. Optional left shifts via SHIFT_ARB_LEFT_EN.
// Rev    : 1.0 - initial release
// ============================================================================
module shift_req_arbiter #(
  parameter int N_REQ      = 2,
  parameter int PRIO_RESET = 0
) (
  input  wire logic          i_clk,
  input  wire logic          i_reset,
  shift_req_arbiter_if.slave bus
);
  localparam int              ID_W         = $clog2(N_REQ);
  localparam logic [ID_W-1:0] C_PRIO_RESET = ID_W'(PRIO_RESET);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [ID_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [31:0]     op_data_q, op_data_d;
  logic [4:0]      op_shamt_q, op_shamt_d;
  logic            op_arith_q, op_arith_d;
  logic [ID_W-1:0] op_id_q, op_id_d;
  logic            rsp_valid_q, rsp_valid_d;
  logic [31:0]     rsp_data_q, rsp_data_d;
  logic [ID_W-1:0] rsp_id_q, rsp_id_d;
  logic            busy_q, busy_d;

  logic            grant_vld;
  logic [ID_W-1:0] grant_id;
  logic [ID_W-1:0] cand;
  logic [31:0]     sh_in;
  logic            sh_fill;
  logic [32:0]     sh_ext;
  logic [31:0]     shift_res;

  // Scan from the farthest offset down so the lowest offset from rr_ptr wins.
  always_comb begin
    grant_vld = 1'b0;
    grant_id  = '0;
    cand      = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      cand = ID_W'((int'(rr_ptr_q) + i) % N_REQ);
      if (bus.req_valid[cand]) begin
        grant_vld = 1'b1;
        grant_id  = cand;
      end
    end
  end

  always_comb begin
    bus.req_ready = '0;
    if (!i_reset && state_q == S_IDLE && grant_vld) begin
      bus.req_ready[grant_id] = 1'b1;
    end
  end

`ifdef SHIFT_ARB_LEFT_EN
  logic op_left_q, op_left_d;

  function automatic logic [31:0] bit_rev(input logic [31:0] v);
    logic [31:0] r;
    for (int b = 0; b < 32; b++) begin
      r[b] = v[31-b];
    end
    return r;
  endfunction

  // Left shift = reverse, logical right shift, reverse back.
  always_comb begin
    sh_in   = op_left_q ? bit_rev(op_data_q) : op_data_q;
    sh_fill = !op_left_q && op_arith_q && op_data_q[31];
    sh_ext  = $signed({sh_fill, sh_in}) >>> op_shamt_q;
    shift_res = op_left_q ? bit_rev(sh_ext[31:0]) : sh_ext[31:0];
  end
`else
  logic unused_left;
  assign unused_left = ^bus.req_left;

  always_comb begin
    sh_in     = op_data_q;
    sh_fill   = op_arith_q && op_data_q[31];
    sh_ext    = $signed({sh_fill, sh_in}) >>> op_shamt_q;
    shift_res = sh_ext[31:0];
  end
`endif

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    op_data_d   = op_data_q;
    op_shamt_d  = op_shamt_q;
    op_arith_d  = op_arith_q;
    op_id_d     = op_id_q;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    rsp_id_d    = rsp_id_q;
`ifdef SHIFT_ARB_LEFT_EN
    op_left_d   = op_left_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (grant_vld) begin
          for (int k = 0; k < N_REQ; k++) begin
            if (grant_id == ID_W'(k)) begin
              op_data_d  = bus.req_data[k*32 +: 32];
              op_shamt_d = bus.req_shamt[k*5 +: 5];
              op_arith_d = bus.req_arith[k];
`ifdef SHIFT_ARB_LEFT_EN
              op_left_d  = bus.req_left[k];
`endif
            end
          end
          op_id_d  = grant_id;
          rr_ptr_d = ID_W'((int'(grant_id) + 1) % N_REQ);
          state_d  = S_EXEC;
        end
      end
      S_EXEC: begin
        rsp_data_d  = shift_res;
        rsp_id_d    = op_id_q;
        rsp_valid_d = 1'b1;
        state_d     = S_RESP;
      end
      S_RESP: begin
        if (bus.rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q     <= S_IDLE;
      rr_ptr_q    <= C_PRIO_RESET;
      op_data_q   <= '0;
      op_shamt_q  <= '0;
      op_arith_q  <= 1'b0;
      op_id_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_id_q    <= '0;
      busy_q      <= 1'b0;
`ifdef SHIFT_ARB_LEFT_EN
      op_left_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      op_data_q   <= op_data_d;
      op_shamt_q  <= op_shamt_d;
      op_arith_q  <= op_arith_d;
      op_id_q     <= op_id_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_id_q    <= rsp_id_d;
      busy_q      <= busy_d;
`ifdef SHIFT_ARB_LEFT_EN
      op_left_q   <= op_left_d;
`endif
    end
  end

  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_data  = rsp_data_q;
  assign bus.rsp_id    = rsp_id_q;
  assign bus.busy      = busy_q;
endmodule
`default_nettype wire
